// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl
// Description : Pipeline hazard/stall controller. It produces the freeze,
//               bubble and flush controls for the IF/ID, ID/EXE and EXE/MEM
//               pipeline registers. It covers load-use hazards, cache misses
//               and taken jumps.
//               Optional: define STALL_PERF_CNT_EN for stall performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl #(
    parameter int BUBBLE_CYCLES = 1,
    parameter int MEM_TIMEOUT   = 255,
    parameter int FLUSH_CYCLES  = 1
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        exe_mem_to_reg,
    input  logic        exe_reg_write,
    input  logic [4:0]  exe_dst,
    input  logic        mem_req,
    input  logic        mem_ready,
    input  logic        jump_taken,
    output logic        freeze_pc,
    output logic        freeze_if_id,
    output logic        freeze_id_exe,
    output logic        freeze_exe_mem,
    output logic        bubble_id_exe,
    output logic        flush_if_id,
    output logic [1:0]  stall_state,
    output logic        mem_timeout
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0] perf_load_stalls,
    output logic [31:0] perf_mem_stalls,
    output logic [31:0] perf_flushes
`endif
);

    localparam logic [1:0]  c_ST_RUN      = 2'd0;
    localparam logic [1:0]  c_ST_LOAD_USE = 2'd1;
    localparam logic [1:0]  c_ST_MEM_WAIT = 2'd2;
    localparam logic [1:0]  c_ST_FLUSH    = 2'd3;

    localparam logic [2:0]  c_BUB_LOAD = 3'(BUBBLE_CYCLES - 1);
    localparam logic [2:0]  c_FLS_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [15:0] c_TMO      = 16'(MEM_TIMEOUT);

    logic [1:0]  r_state;
    logic [1:0]  r_saved_state;
    logic [2:0]  r_cnt;
    logic [15:0] r_wait_cnt;
    logic        r_mem_timeout;

    logic [1:0]  w_state_nxt;
    logic [1:0]  w_saved_nxt;
    logic [2:0]  w_cnt_nxt;
    logic [15:0] w_wait_nxt;
    logic        w_timeout_nxt;

    logic        w_hazard;
    logic        w_miss;

    assign w_hazard = exe_mem_to_reg & exe_reg_write & (exe_dst != 5'd0) &
                      ((exe_dst == id_rs) | (id_uses_rt & (exe_dst == id_rt)));
    assign w_miss   = mem_req & ~mem_ready;

    // State register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state       <= c_ST_RUN;
            r_saved_state <= c_ST_RUN;
            r_cnt         <= 3'd0;
            r_wait_cnt    <= 16'd0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_saved_state <= w_saved_nxt;
            r_cnt         <= w_cnt_nxt;
            r_wait_cnt    <= w_wait_nxt;
            r_mem_timeout <= w_timeout_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt   = r_state;
        w_saved_nxt   = r_saved_state;
        w_cnt_nxt     = r_cnt;
        w_wait_nxt    = r_wait_cnt;
        w_timeout_nxt = r_mem_timeout;
        if (w_miss) begin
            // The interrupted state and its count survive the miss untouched.
            w_state_nxt = c_ST_MEM_WAIT;
            if (r_state != c_ST_MEM_WAIT) begin
                w_saved_nxt = r_state;
            end else begin
                if (r_wait_cnt != c_TMO) begin
                    w_wait_nxt = r_wait_cnt + 16'd1;
                end
                if (r_wait_cnt + 16'd1 == c_TMO) begin
                    w_timeout_nxt = 1'b1;
                end
            end
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    if (jump_taken) begin
                        if (FLUSH_CYCLES > 1) begin
                            w_state_nxt = c_ST_FLUSH;
                            w_cnt_nxt   = c_FLS_LOAD;
                        end
                    end else if (w_hazard) begin
                        if (BUBBLE_CYCLES > 1) begin
                            w_state_nxt = c_ST_LOAD_USE;
                            w_cnt_nxt   = c_BUB_LOAD;
                        end
                    end
                end
                c_ST_LOAD_USE: begin
                    if (jump_taken) begin
                        if (FLUSH_CYCLES > 1) begin
                            w_state_nxt = c_ST_FLUSH;
                            w_cnt_nxt   = c_FLS_LOAD;
                        end else begin
                            w_state_nxt = c_ST_RUN;
                            w_cnt_nxt   = 3'd0;
                        end
                    end else if (r_cnt == 3'd1) begin
                        w_state_nxt = c_ST_RUN;
                        w_cnt_nxt   = 3'd0;
                    end else begin
                        w_cnt_nxt = r_cnt - 3'd1;
                    end
                end
                c_ST_MEM_WAIT: begin
                    w_state_nxt = r_saved_state;
                    w_wait_nxt  = 16'd0;
                end
                c_ST_FLUSH: begin
                    if (r_cnt == 3'd1) begin
                        w_state_nxt = c_ST_RUN;
                        w_cnt_nxt   = 3'd0;
                    end else begin
                        w_cnt_nxt = r_cnt - 3'd1;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_RUN;
                    w_cnt_nxt   = 3'd0;
                end
            endcase
        end
    end

    // Output logic; gated by rst_b so outputs drop the instant reset asserts
    always_comb begin
        freeze_pc      = 1'b0;
        freeze_if_id   = 1'b0;
        freeze_id_exe  = 1'b0;
        freeze_exe_mem = 1'b0;
        bubble_id_exe  = 1'b0;
        flush_if_id    = 1'b0;
        if (rst_b) begin
            if (w_miss) begin
                freeze_pc      = 1'b1;
                freeze_if_id   = 1'b1;
                freeze_id_exe  = 1'b1;
                freeze_exe_mem = 1'b1;
            end else begin
                case (r_state)
                    c_ST_RUN, c_ST_LOAD_USE: begin
                        if (jump_taken) begin
                            flush_if_id   = 1'b1;
                            bubble_id_exe = 1'b1;
                        end else if (w_hazard || r_state == c_ST_LOAD_USE) begin
                            freeze_pc     = 1'b1;
                            freeze_if_id  = 1'b1;
                            bubble_id_exe = 1'b1;
                        end
                    end
                    c_ST_FLUSH: begin
                        flush_if_id   = 1'b1;
                        bubble_id_exe = 1'b1;
                    end
                    default: begin
                        freeze_pc = 1'b0;
                    end
                endcase
            end
        end
    end

    assign stall_state = r_state;
    assign mem_timeout = r_mem_timeout;

`ifdef STALL_PERF_CNT_EN
    logic [31:0] r_perf_load;
    logic [31:0] r_perf_mem;
    logic [31:0] r_perf_flush;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_perf_load  <= 32'd0;
            r_perf_mem   <= 32'd0;
            r_perf_flush <= 32'd0;
        end else begin
            if (freeze_pc & bubble_id_exe) begin
                r_perf_load <= r_perf_load + 32'd1;
            end
            if (freeze_exe_mem) begin
                r_perf_mem <= r_perf_mem + 32'd1;
            end
            if (flush_if_id) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
        end
    end

    assign perf_load_stalls = r_perf_load;
    assign perf_mem_stalls  = r_perf_mem;
    assign perf_flushes     = r_perf_flush;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_stall_ctrl
// Description : Self-checking bench for hazard_stall_ctrl: directed scenarios
//               plus randomized traffic against a counter-based reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

    localparam int BUB = 3;
    localparam int TMO = 3;
    localparam int FLS = 2;

    logic        clk;
    logic        rst_b;
    logic [4:0]  id_rs, id_rt, exe_dst;
    logic        id_uses_rt, exe_mem_to_reg, exe_reg_write;
    logic        mem_req, mem_ready, jump_taken;
    logic        freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem;
    logic        bubble_id_exe, flush_if_id, mem_timeout;
    logic [1:0]  stall_state;
`ifdef STALL_PERF_CNT_EN
    logic [31:0] perf_load_stalls, perf_mem_stalls, perf_flushes;
`endif

    // {freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem, bubble, flush}
    logic [5:0]  outs;
    assign outs = {freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem,
                   bubble_id_exe, flush_if_id};

    int total = 0;
    int bad   = 0;

    hazard_stall_ctrl #(
        .BUBBLE_CYCLES (BUB),
        .MEM_TIMEOUT   (TMO),
        .FLUSH_CYCLES  (FLS)
    ) dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rt     (id_uses_rt),
        .exe_mem_to_reg (exe_mem_to_reg),
        .exe_reg_write  (exe_reg_write),
        .exe_dst        (exe_dst),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .jump_taken     (jump_taken),
        .freeze_pc      (freeze_pc),
        .freeze_if_id   (freeze_if_id),
        .freeze_id_exe  (freeze_id_exe),
        .freeze_exe_mem (freeze_exe_mem),
        .bubble_id_exe  (bubble_id_exe),
        .flush_if_id    (flush_if_id),
        .stall_state    (stall_state),
        .mem_timeout    (mem_timeout)
`ifdef STALL_PERF_CNT_EN
        ,
        .perf_load_stalls (perf_load_stalls),
        .perf_mem_stalls  (perf_mem_stalls),
        .perf_flushes     (perf_flushes)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit expired");
        $fatal(1);
    end

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                          input logic m2r, input logic rw, input logic [4:0] dst,
                          input logic req, input logic rdy, input logic jmp);
        id_rs = rs; id_rt = rt; id_uses_rt = urt;
        exe_mem_to_reg = m2r; exe_reg_write = rw; exe_dst = dst;
        mem_req = req; mem_ready = rdy; jump_taken = jmp;
    endtask

    task automatic idle();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        set_in(5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
        #1;
        total++; if (outs !== 6'b000000) begin bad++; $display("FAIL rst_outs got=%b want=%b", outs, 6'b000000); end
        total++; if (stall_state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", stall_state); end
        total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL rst_tmo got=%b want=0", mem_timeout); end
        @(negedge clk);
        #1;
        total++; if (outs !== 6'b000000) begin bad++; $display("FAIL rst_hold_outs got=%b want=%b", outs, 6'b000000); end
        @(negedge clk);
        rst_b = 1'b1;
        idle();
        #1;
        total++; if (outs !== 6'b000000 || stall_state !== 2'd0) begin
            bad++; $display("FAIL rst_release got=%b/%0d want=000000/0", outs, stall_state); end
    endtask

    task automatic test_load_use();
        logic [5:0] exp_o [4] = '{6'b110010, 6'b110010, 6'b110010, 6'b000000};
        logic [1:0] exp_s [4] = '{2'd0, 2'd1, 2'd1, 2'd0};
        do_reset();
        set_in(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(negedge clk);
                idle();
            end
            #1;
            total++; if (outs !== exp_o[i]) begin bad++; $display("FAIL lu_outs[%0d] got=%b want=%b", i, outs, exp_o[i]); end
            total++; if (stall_state !== exp_s[i]) begin bad++; $display("FAIL lu_state[%0d] got=%0d want=%0d", i, stall_state, exp_s[i]); end
        end
    endtask

    task automatic test_no_hazard();
        logic [4:0] rs  [5] = '{5'd0, 5'd7, 5'd0, 5'd3, 5'd0};
        logic [4:0] rt  [5] = '{5'd0, 5'd0, 5'd9, 5'd3, 5'd9};
        logic       urt [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic       m2r [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic       rw  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [4:0] dst [5] = '{5'd0, 5'd7, 5'd9, 5'd3, 5'd9};
        logic [5:0] exp [5] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b110010};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            set_in(rs[i], rt[i], urt[i], m2r[i], rw[i], dst[i], 1'b0, 1'b0, 1'b0);
            #1;
            total++; if (outs !== exp[i]) begin bad++; $display("FAIL nohaz_outs[%0d] got=%b want=%b", i, outs, exp[i]); end
        end
    endtask

    task automatic test_mem_miss();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
            #1;
            total++; if (outs !== 6'b111100) begin bad++; $display("FAIL miss_outs[%0d] got=%b want=111100", i, outs); end
            total++; if (stall_state !== ((i == 0) ? 2'd0 : 2'd2)) begin
                bad++; $display("FAIL miss_state[%0d] got=%0d want=%0d", i, stall_state, (i == 0) ? 0 : 2); end
        end
        @(negedge clk);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        #1;
        total++; if (outs !== 6'b000000 || stall_state !== 2'd2) begin
            bad++; $display("FAIL miss_release got=%b/%0d want=000000/2", outs, stall_state); end
        @(negedge clk);
        idle();
        #1;
        total++; if (stall_state !== 2'd0) begin bad++; $display("FAIL miss_back_run got=%0d want=0", stall_state); end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
            #1;
            total++; if (mem_timeout !== (i == 4)) begin
                bad++; $display("FAIL tmo[%0d] got=%b want=%b", i, mem_timeout, (i == 4)); end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle();
            #1;
            total++; if (mem_timeout !== 1'b1) begin bad++; $display("FAIL tmo_sticky[%0d] got=%b want=1", i, mem_timeout); end
        end
        #2;
        rst_b = 1'b0;
        #1;
        total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL tmo_clear got=%b want=0", mem_timeout); end
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    task automatic test_jump_hazard();
        do_reset();
        set_in(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
        #1;
        total++; if (outs !== 6'b000011) begin bad++; $display("FAIL jh_c0 got=%b want=000011", outs); end
        @(negedge clk);
        jump_taken = 1'b0;
        #1;
        total++; if (outs !== 6'b000011 || stall_state !== 2'd3) begin
            bad++; $display("FAIL jh_c1 got=%b/%0d want=000011/3", outs, stall_state); end
        @(negedge clk);
        idle();
        #1;
        total++; if (outs !== 6'b000000 || stall_state !== 2'd0) begin
            bad++; $display("FAIL jh_c2 got=%b/%0d want=000000/0", outs, stall_state); end
    endtask

    task automatic test_miss_resume();
        logic [5:0] exp_o [7] = '{6'b110010, 6'b111100, 6'b111100, 6'b000000, 6'b110010, 6'b110010, 6'b000000};
        logic [1:0] exp_s [7] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
        logic       req   [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       rdy   [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 0) set_in(5'd4, 5'd0, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
            else        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, req[i], rdy[i], 1'b0);
            #1;
            total++; if (outs !== exp_o[i] || stall_state !== exp_s[i]) begin
                bad++; $display("FAIL resume[%0d] got=%b/%0d want=%b/%0d", i, outs, stall_state, exp_o[i], exp_s[i]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_in(5'd6, 5'd0, 1'b0, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        idle();
        #1;
        total++; if (outs !== 6'b110010 || stall_state !== 2'd1) begin
            bad++; $display("FAIL rmid_pre got=%b/%0d want=110010/1", outs, stall_state); end
        #2;
        rst_b = 1'b0;
        #1;
        total++; if (outs !== 6'b000000 || stall_state !== 2'd0) begin
            bad++; $display("FAIL rmid_async got=%b/%0d want=000000/0", outs, stall_state); end
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        total++; if (outs !== 6'b000000 || stall_state !== 2'd0) begin
            bad++; $display("FAIL rmid_post got=%b/%0d want=000000/0", outs, stall_state); end
    endtask

    task automatic test_random();
        int   bub_left = 0, flush_left = 0, wait_cycles = 0, miss_left = 0;
        bit   waiting = 0, tmo = 0, miss, haz, exp_tmo;
        logic [5:0] exp_o;
        logic [1:0] exp_s;
        logic [4:0] rs, rt, dst;
        logic urt, m2r, rw, req, rdy, jmp;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (miss_left == 0 && $urandom_range(0, 99) < 8) miss_left = int'($urandom_range(1, 6));
            if (miss_left > 0) begin
                req = 1'b1; rdy = 1'b0; miss_left--;
            end else begin
                req = 1'($urandom_range(0, 1)); rdy = 1'b1;
            end
            rs  = 5'($urandom_range(0, 3));
            rt  = 5'($urandom_range(0, 3));
            dst = 5'($urandom_range(0, 3));
            urt = 1'($urandom_range(0, 1));
            m2r = 1'($urandom_range(0, 1));
            rw  = ($urandom_range(0, 9) < 7);
            jmp = ($urandom_range(0, 99) < 12);
            set_in(rs, rt, urt, m2r, rw, dst, req, rdy, jmp);
            #1;
            miss = req && !rdy;
            haz  = m2r && rw && (dst != 0) && (dst == rs || (urt && dst == rt));
            exp_s = waiting ? 2'd2 : (flush_left > 0) ? 2'd3 : (bub_left > 0) ? 2'd1 : 2'd0;
            exp_tmo = tmo;
            if (miss) begin
                exp_o = 6'b111100;
                if (waiting) begin
                    wait_cycles++;
                    if (wait_cycles == TMO) tmo = 1;
                end
                waiting = 1;
            end else if (waiting) begin
                exp_o = 6'b000000; waiting = 0; wait_cycles = 0;
            end else if (flush_left > 0) begin
                exp_o = 6'b000011; flush_left--;
            end else if (jmp) begin
                exp_o = 6'b000011; flush_left = FLS - 1; bub_left = 0;
            end else if (bub_left > 0) begin
                exp_o = 6'b110010; bub_left--;
            end else if (haz) begin
                exp_o = 6'b110010; bub_left = BUB - 1;
            end else begin
                exp_o = 6'b000000;
            end
            total++; if (outs !== exp_o) begin bad++; $display("FAIL rnd_outs[%0d] got=%b want=%b", i, outs, exp_o); end
            total++; if (stall_state !== exp_s) begin bad++; $display("FAIL rnd_state[%0d] got=%0d want=%0d", i, stall_state, exp_s); end
            total++; if (mem_timeout !== exp_tmo) begin bad++; $display("FAIL rnd_tmo[%0d] got=%b want=%b", i, mem_timeout, exp_tmo); end
            total++; if (freeze_id_exe && bubble_id_exe) begin bad++; $display("FAIL rnd_excl[%0d] got=11 want=not both", i); end
        end
    endtask

    initial begin
        rst_b = 1'b0;
        idle();
        test_reset();
        test_load_use();
        test_no_hazard();
        test_mem_miss();
        test_timeout();
        test_jump_hazard();
        test_miss_resume();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
